// File: rtl/pwm_decoder.sv
// rtl/pwm_decoder.sv - recovers the duty word from a rising-edge aligned PWM line
// One valid pulse per well-formed frame, err pulse on malformed frames.
module pwm_decoder #(
  parameter int WIDTH       = 8,
  parameter int PERIOD      = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] duty,
  output logic             valid,
  output logic             locked,
  output logic             err
);

  localparam int CW = $clog2(PERIOD) + 1;
  localparam int HSAT = (PERIOD < 2**WIDTH) ? PERIOD : 2**WIDTH - 1;
  localparam logic [CW-1:0]    P_FULL = CW'(PERIOD);
  localparam logic [CW-1:0]    P_LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0]    C_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] H_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] H_MAX  = WIDTH'(HSAT);

  typedef enum logic [1:0] {IDLE, ACQUIRE, MEASURE_HIGH, MEASURE_LOW} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   prev;
  logic                   rise;
  logic                   fall;
  logic [CW-1:0]          frame_cnt;
  logic [CW-1:0]          run_cnt;
  logic [WIDTH-1:0]       high_cnt;

  assign s = sync[SYNC_STAGES-1];

  function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] v);
    return (v >= P_FULL) ? P_FULL : v + C_ONE;
  endfunction

  function automatic logic [WIDTH-1:0] high_inc(input logic [WIDTH-1:0] v);
    return (v >= H_MAX) ? H_MAX : v + H_ONE;
  endfunction

  // rise/fall are registered; prev is the line level aligned with them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
      prev <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pwm_in};
      prev <= s;
      rise <= s & ~prev;
      fall <= ~s & prev;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      frame_cnt <= '0;
      run_cnt   <= '0;
      high_cnt  <= '0;
      duty      <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      if (!en) begin
        state     <= IDLE;
        frame_cnt <= '0;
        run_cnt   <= '0;
        high_cnt  <= '0;
        locked    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            frame_cnt <= '0;
            run_cnt   <= '0;
            high_cnt  <= '0;
            locked    <= 1'b0;
            state     <= ACQUIRE;
          end
          ACQUIRE: begin
            if (rise) begin
              state     <= MEASURE_HIGH;
              frame_cnt <= C_ONE;
              high_cnt  <= H_ONE;
              run_cnt   <= '0;
            end else if (fall) begin
              run_cnt <= C_ONE;
            end else if (run_cnt >= P_LAST) begin
              // a whole frame at one level: low is the 0% duty, high is stuck
              run_cnt <= '0;
              if (prev) begin
                err    <= 1'b1;
                locked <= 1'b0;
              end else begin
                duty   <= '0;
                valid  <= 1'b1;
                locked <= 1'b1;
              end
            end else begin
              run_cnt <= cnt_inc(run_cnt);
            end
          end
          MEASURE_HIGH: begin
            if (fall) begin
              frame_cnt <= cnt_inc(frame_cnt);
              state     <= MEASURE_LOW;
            end else if (frame_cnt >= P_LAST) begin
              err       <= 1'b1;
              locked    <= 1'b0;
              frame_cnt <= '0;
              high_cnt  <= '0;
              run_cnt   <= '0;
              state     <= ACQUIRE;
            end else begin
              frame_cnt <= cnt_inc(frame_cnt);
              high_cnt  <= high_inc(high_cnt);
            end
          end
          MEASURE_LOW: begin
            if (rise) begin
              if (frame_cnt == P_FULL) begin
                duty   <= high_cnt;
                valid  <= 1'b1;
                locked <= 1'b1;
              end else begin
                err    <= 1'b1;
                locked <= 1'b0;
              end
              frame_cnt <= C_ONE;
              high_cnt  <= H_ONE;
              state     <= MEASURE_HIGH;
            end else if (frame_cnt >= P_FULL) begin
              // frame overran while low; ACQUIRE decides whether it is 0%
              locked    <= 1'b0;
              frame_cnt <= '0;
              high_cnt  <= '0;
              run_cnt   <= C_ONE;
              state     <= ACQUIRE;
            end else begin
              frame_cnt <= cnt_inc(frame_cnt);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_decoder.sv
// tb/tb_pwm_decoder.sv - self-checking bench for pwm_decoder
module tb_pwm_decoder;
  localparam int WIDTH  = 8;
  localparam int PERIOD = 256;
  localparam int SYNC   = 2;
  localparam int LAT    = SYNC + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic pwm_in = 1'b0;
  logic [WIDTH-1:0] duty;
  logic valid, locked, err;

  always #5 clk = ~clk;

  pwm_decoder #(.WIDTH(WIDTH), .PERIOD(PERIOD), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .en(en), .pwm_in(pwm_in),
    .duty(duty), .valid(valid), .locked(locked), .err(err)
  );

  typedef struct {int duty; int cyc;} exp_t;
  typedef struct {int duty; int frames; int exp_locked; int exp_err;} vec_t;

  exp_t sb_q[$];
  vec_t vecs[4];
  int n_tests = 0, n_fail = 0, cyc = 0, prev_d = -1, overlap = 0;
  bit sb_on = 1'b0;
  int ph_duty, ph_valid, ph_err, ph_bad_duty, ph_bad_gap, ph_unlock;
  int ph_first_valid, ph_first_duty, ph_last_valid;
  int f5_cyc;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic ph_clear(input int d);
    ph_duty = d; ph_valid = 0; ph_err = 0; ph_bad_duty = 0; ph_bad_gap = 0;
    ph_unlock = 0; ph_first_valid = -1; ph_first_duty = -1; ph_last_valid = -1;
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (valid && err) overlap++;
    if (err) ph_err++;
    if (!locked) ph_unlock++;
    if (valid) begin
      ph_valid++;
      if (ph_first_valid < 0) begin
        ph_first_valid = cyc;
        ph_first_duty = int'(duty);
      end
      if (ph_last_valid >= 0 && cyc - ph_last_valid != PERIOD) ph_bad_gap++;
      ph_last_valid = cyc;
      if (int'(duty) != ph_duty) ph_bad_duty++;
      if (sb_on) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected_valid: got duty %0d expected no valid (cycle %0d)", duty, cyc);
        end else begin
          e = sb_q.pop_front();
          check("sb_duty", int'(duty), e.duty);
          check("sb_latency", cyc - e.cyc, LAT);
        end
      end
    end
  endtask

  // Generator cycle c of a frame; a rise closing a measured frame predicts its duty.
  task automatic gen_cycle(input int d, input int c);
    exp_t e;
    pwm_in = (c < d);
    if (c == 0) begin
      if (sb_on && d > 0 && prev_d > 0) begin
        e.duty = prev_d;
        e.cyc = cyc;
        sb_q.push_back(e);
      end
      prev_d = d;
    end
    step();
  endtask

  task automatic gen_frames(input int d, input int n);
    for (int f = 0; f < n; f++)
      for (int c = 0; c < PERIOD; c++) gen_cycle(d, c);
  endtask

  task automatic hand(input logic lvl, input int n);
    pwm_in = lvl;
    repeat (n) step();
  endtask

  initial begin
    vecs[0] = '{64, 4, 1, 0};
    vecs[1] = '{1, 3, 1, 0};
    vecs[2] = '{255, 3, 1, 0};
    vecs[3] = '{128, 2, 1, 0};
    ph_clear(0);

    repeat (2) step();
    check("reset_duty", int'(duty), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_locked", int'(locked), 0);
    check("reset_err", int'(err), 0);
    rst = 1'b1;
    en = 1'b1;
    repeat (5) step();

    sb_on = 1'b1;
    prev_d = -1;
    for (int i = 0; i < 4; i++) begin
      ph_clear(vecs[i].duty);
      for (int f = 0; f < vecs[i].frames; f++)
        for (int c = 0; c < PERIOD; c++) begin
          if (i == 0 && f == 1 && c == 0) check("locked_before_first_frame", int'(locked), 0);
          gen_cycle(vecs[i].duty, c);
        end
      check("vec_err_count", ph_err, vecs[i].exp_err);
      check("vec_locked", int'(locked), vecs[i].exp_locked);
      check("vec_pending", sb_q.size(), 0);
    end

    // 128 switched to 0%
    sb_on = 1'b0;
    ph_clear(0);
    gen_frames(0, 4);
    hand(1'b0, 128);
    check("zero_valid_count", ph_valid, 4);
    check("zero_bad_duty", ph_bad_duty, 0);
    check("zero_bad_gap", ph_bad_gap, 0);
    check("zero_err", ph_err, 0);
    check("zero_unlock_seen", int'(ph_unlock > 0), 1);
    check("zero_locked_end", int'(locked), 1);

    // 200-clock frames, high 50
    ph_clear(0);
    for (int f = 0; f < 4; f++) begin
      hand(1'b1, 50);
      hand(1'b0, 150);
    end
    check("short_err_count", ph_err, 3);
    check("short_valid_count", ph_valid, 0);
    check("short_locked", int'(locked), 0);

    ph_clear(0);
    hand(1'b0, 250);
    check("overrun_valid", ph_valid, 0);
    check("overrun_err", ph_err, 0);

    // stuck high for 300 clocks
    ph_clear(0);
    hand(1'b1, 300);
    hand(1'b0, 100);
    check("stuck_err_count", ph_err, 1);
    check("stuck_valid_count", ph_valid, 0);
    check("stuck_locked", int'(locked), 0);

    // reset mid-MEASURE_HIGH
    sb_on = 1'b1;
    prev_d = -1;
    gen_frames(64, 3);
    for (int c = 0; c < 20; c++) gen_cycle(64, c);
    rst = 1'b0;
    #1;
    check("rst_duty", int'(duty), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_pending", sb_q.size(), 0);
    sb_on = 1'b0;
    ph_clear(64);
    gen_cycle(64, 20);
    rst = 1'b1;
    for (int c = 21; c < PERIOD; c++) gen_cycle(64, c);
    gen_frames(64, 1);
    f5_cyc = cyc;
    gen_frames(64, 1);
    check("rst_first_valid_cycle", ph_first_valid, f5_cyc + LAT);
    check("rst_first_valid_duty", ph_first_duty, 64);

    // en dropped for 10 clocks mid-frame
    sb_on = 1'b1;
    prev_d = 64;
    gen_frames(64, 1);
    for (int c = 0; c < 100; c++) gen_cycle(64, c);
    ph_clear(64);
    en = 1'b0;
    gen_cycle(64, 100);
    check("en_off_locked", int'(locked), 0);
    check("en_off_duty", int'(duty), 64);
    prev_d = -1;
    for (int c = 101; c < 110; c++) gen_cycle(64, c);
    en = 1'b1;
    for (int c = 110; c < PERIOD; c++) gen_cycle(64, c);
    gen_frames(64, 1);
    check("en_locked_before_relock", int'(locked), 0);
    for (int c = 0; c < LAT + 4; c++) gen_cycle(64, c);
    check("en_relocked", int'(locked), 1);
    check("en_valid_count", ph_valid, 1);
    check("en_err_count", ph_err, 0);
    check("en_pending", sb_q.size(), 0);

    check("valid_err_overlap", overlap, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
